// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the mem_responder block.
// Optional feature macro: MEM_RESPONDER_ADDR_CHECK_EN (see mem_responder.sv).
package mem_responder_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_DEPTH  = 256;
  localparam int MEM_RD_LAT = 2;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_BUSY = 2'd1,
    M_RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                    we;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   wdata;
    logic [MEM_DATA_W/8-1:0] wmask;
  } mem_req_t;

  // Value loaded into the latency down-counter on accept. The M_BUSY state
  // lasts RD_LAT-1 cycles and exits when the counter reads zero.
  function automatic int cnt_load(input int rd_lat);
    return (rd_lat > 1) ? (rd_lat - 2) : 0;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the core (master) and mem_responder (slave).
interface mem_responder_if #(
  parameter int ADDR_W = mem_responder_pkg::MEM_ADDR_W,
  parameter int DATA_W = mem_responder_pkg::MEM_DATA_W
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array: DEPTH x DATA_W word storage, byte-masked write, registered read.
// Contents are not reset; the read register only changes when re is high.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wmask,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Commit enabled bytes of the write word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wmask[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Capture a new read word only on request, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory endpoint with fixed response latency.
// Optional feature macro: MEM_RESPONDER_ADDR_CHECK_EN
//   defined   -> req_addr >= DEPTH is flagged with rsp_err, no write, rdata 0
//   undefined -> the low address bits index the array (addresses alias)
//
// state  | meaning
// M_IDLE | ready for a request; writes commit on the accept cycle
// M_BUSY | latency down-counter running toward the response
// M_RESP | response held on the bus until rsp_ready
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int RD_LAT = MEM_RD_LAT
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(cnt_load(RD_LAT));

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rd_q, rd_d;

  mem_req_t          req;
  logic              req_ready_w;
  logic              accept;
  logic              addr_err;
  logic              go_resp;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] arr_rdata;

  // Snapshot of the incoming request fields.
  always_comb begin
    req.we    = bus.req_we;
    req.addr  = bus.req_addr;
    req.wdata = bus.req_wdata;
    req.wmask = bus.req_wmask;
  end

  assign req_ready_w = (state_q == M_IDLE) & ~rst;
  assign accept      = bus.req_valid & req_ready_w;
  assign req_idx     = req.addr[IDX_W-1:0];

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  logic err_q, err_d;

  assign addr_err = ({1'b0, req.addr} >= (ADDR_W + 1)'(DEPTH));

  // Error flag follows the request into the response; cleared by reset.
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = addr_err;
    end
    if (rst) begin
      err_d = 1'b0;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    err_q <= err_d;
  end

  assign bus.rsp_err = err_q & (state_q == M_RESP);
`else
  logic unused_addr_hi;

  assign addr_err       = 1'b0;
  assign unused_addr_hi = ^(ADDR_W'(req.addr) >> IDX_W);
  assign bus.rsp_err    = 1'b0;
`endif

  // Request FSM with latency down-counter; reset is folded into the next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    go_resp = 1'b0;
    unique case (state_q)
      M_IDLE: begin
        if (accept) begin
          idx_d = req_idx;
          rd_d  = ~req.we & ~addr_err;
          if (RD_LAT > 1) begin
            state_d = M_BUSY;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = M_RESP;
            go_resp = 1'b1;
          end
        end
      end
      M_BUSY: begin
        if (cnt_q == '0) begin
          state_d = M_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      M_RESP: begin
        if (bus.rsp_ready) begin
          state_d = M_IDLE;
        end
      end
      default: begin
        state_d = M_IDLE;
      end
    endcase
    if (rst) begin
      state_d = M_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      rd_d    = 1'b0;
      go_resp = 1'b0;
    end
  end

  // FSM and request latch registers.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    idx_q   <= idx_d;
    rd_q    <= rd_d;
  end

  // Writes land on the accept cycle; reads are issued on entry to M_RESP so the
  // array's read register holds the word for the whole response.
  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk    (clk),
    .we     (accept & req.we & ~addr_err),
    .waddr  (req_idx),
    .wdata  (req.wdata),
    .wmask  (req.wmask),
    .re     (go_resp & rd_d),
    .raddr  (idx_d),
    .rdata  (arr_rdata)
  );

  assign bus.req_ready = req_ready_w;
  assign bus.rsp_valid = (state_q == M_RESP);
  assign bus.rsp_rdata = ((state_q == M_RESP) && rd_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder against a word-array model.
module tb_mem_responder;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [31:0] model_mem [DEPTH];
  int          acc_q[$];
  int          rsp_q[$];
  logic [31:0] rsp_data_q[$];

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake log: edge index of every accept and every completed response.
  always @(posedge clk) begin
    if (!rst && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    if (bus.rsp_valid && bus.rsp_ready) begin
      rsp_q.push_back(cyc);
      rsp_data_q.push_back(bus.rsp_rdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: word array, byte-masked writes, optional range error.
  function automatic void model_access(input logic we, input logic [9:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] wmask,
                                       output logic [31:0] rdata, output logic err);
    int idx;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    err = (int'(addr) >= DEPTH);
`else
    err = 1'b0;
`endif
    idx   = int'(addr) % DEPTH;
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      rdata = model_mem[idx];
    end
  endfunction

  task automatic run_txn(input string tag, input logic we, input logic [9:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask,
                         input int stall, output logic [31:0] obs_rdata);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          waited;
    obs_rdata = 32'h0;
    @(negedge clk);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    bus.req_valid = 1'b1;
    bus.rsp_ready = (stall == 0);
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    model_access(we, addr, wdata, wmask, exp_rdata, exp_err);
    for (int i = 1; i < RD_LAT; i++) begin
      @(negedge clk);
      chk({tag, "_early_valid"}, 32'(bus.rsp_valid), 32'h0);
    end
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'h1);
    chk({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    obs_rdata = bus.rsp_rdata;
    for (int s = 0; s < stall; s++) begin
      if (s == 0) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_wdata = ~wdata;
        bus.req_wmask = 4'hF;
      end
      @(negedge clk);
      chk({tag, "_stall_valid"}, 32'(bus.rsp_valid), 32'h1);
      chk({tag, "_stall_rdata"}, bus.rsp_rdata, exp_rdata);
      chk({tag, "_stall_err"}, 32'(bus.rsp_err), 32'(exp_err));
      chk({tag, "_stall_ready"}, 32'(bus.req_ready), 32'h0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_done_ready"}, 32'(bus.req_ready), 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [31:0] obs, prev44, e_data, wv;
  logic        e_err;
  logic [9:0]  a4 [3];
  logic [31:0] x4 [3];
  int          waited;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'h1);

    // Full write, read back
    run_txn("wr5_full", 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 0, obs);
    chk("wr5_ack_rdata", obs, 32'h0);
    run_txn("rd5_full", 1'b0, 10'd5, 32'h0, 4'h0, 0, obs);
    chk("rd5_full_lit", obs, 32'hDEADBEEF);

    // Partial-mask write merges into existing word
    run_txn("wr5_mask3", 1'b1, 10'd5, 32'h12345678, 4'h3, 0, obs);
    run_txn("rd5_merged", 1'b0, 10'd5, 32'h0, 4'h0, 0, obs);
    chk("rd5_merged_lit", obs, 32'hDEAD5678);

    // Mask 0 write is acknowledged but changes nothing
    run_txn("wr5_mask0", 1'b1, 10'd5, 32'hFFFFFFFF, 4'h0, 0, obs);

    // Backpressure with a competing request that must not be accepted
    run_txn("rd5_stall", 1'b0, 10'd5, 32'h0, 4'h0, 5, obs);
    chk("rd5_stall_lit", obs, 32'hDEAD5678);
    run_txn("rd5_after_stall", 1'b0, 10'd5, 32'h0, 4'h0, 0, obs);
    chk("rd5_after_stall_lit", obs, 32'hDEAD5678);

    // Fill every word
    for (int a = 0; a < DEPTH; a++) begin
      run_txn("fill", 1'b1, 10'(a), $urandom, 4'hF, 0, obs);
    end

    // Out-of-range address: error or alias depending on build
    prev44 = model_mem[44];
    run_txn("wr300", 1'b1, 10'd300, 32'hA5A55A5A, 4'hF, 0, obs);
    run_txn("rd300", 1'b0, 10'd300, 32'h0, 4'h0, 0, obs);
    run_txn("rd44", 1'b0, 10'd44, 32'h0, 4'h0, 0, obs);
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    chk("rd44_unchanged", obs, prev44);
`else
    chk("rd44_alias", obs, 32'hA5A55A5A);
`endif

    // Back-to-back reads with req_valid held high
    for (int i = 0; i < 3; i++) begin
      a4[i] = 10'($urandom_range(0, DEPTH - 1));
      model_access(1'b0, a4[i], 32'h0, 4'h0, x4[i], e_err);
    end
    @(negedge clk);
    acc_q.delete();
    rsp_q.delete();
    rsp_data_q.delete();
    bus.req_we    = 1'b0;
    bus.req_addr  = a4[0];
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    waited = 0;
    while (rsp_q.size() < 3 && waited < 40) begin
      @(negedge clk);
      waited++;
      if (acc_q.size() >= 3) bus.req_valid = 1'b0;
      else bus.req_addr = a4[acc_q.size()];
    end
    bus.req_valid = 1'b0;
    chk("b2b_acc_count", 32'(acc_q.size()), 32'd3);
    chk("b2b_rsp_count", 32'(rsp_q.size()), 32'd3);
    if (acc_q.size() == 3 && rsp_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("b2b_acc_gap", 32'(acc_q[i] - acc_q[0]), 32'(3 * i));
        chk("b2b_rsp_gap", 32'(rsp_q[i] - acc_q[0]), 32'(3 * i + RD_LAT));
        chk("b2b_rdata", rsp_data_q[i], x4[i]);
      end
    end

    // Reset during M_BUSY drops the response but keeps the committed write
    @(negedge clk);
    wv = $urandom;
    bus.req_we    = 1'b1;
    bus.req_addr  = 10'd7;
    bus.req_wdata = wv;
    bus.req_wmask = 4'hF;
    bus.req_valid = 1'b1;
    chk("rstbusy_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst = 1'b1;
    model_access(1'b1, 10'd7, wv, 4'hF, e_data, e_err);
    @(negedge clk);
    chk("rstbusy_ready_low", 32'(bus.req_ready), 32'h0);
    chk("rstbusy_no_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstbusy_ready_release", 32'(bus.req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstbusy_quiet", 32'(bus.rsp_valid), 32'h0);
    end
    run_txn("rd7_after_rst", 1'b0, 10'd7, 32'h0, 4'h0, 0, obs);
    chk("rd7_after_rst_val", obs, wv);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic       r_we;
      logic [9:0] r_addr;
      int         r_stall;
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(DEPTH, 1023))
                                            : 10'($urandom_range(0, DEPTH - 1));
      r_stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_txn("rand", r_we, r_addr, $urandom, 4'($urandom), r_stall, obs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
